// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and framing constants
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side status bundle from the UART receiver to the status register
interface uart_rx_if;
  logic [7:0] recv_data;
  logic       recv_int;
  logic       recv_busy;
  logic       recv_error;
  modport master (output recv_data, recv_int, recv_busy, recv_error);
  modport slave  (input  recv_data, recv_int, recv_busy, recv_error);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick generator, one tick every div+1 clocks, held at zero by clr
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  // tick on terminal count, wrap or hold at zero while cleared
  always_comb begin
    tick  = !clr && (cnt_q == div);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  // counter register
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver (8 data bits, optional parity via UART_RX_PARITY_EN, 1 stop bit)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_odd,
  uart_rx_if.master        rif
);
  rx_state_t  state_q, state_d;
  logic       rx_meta_q, rx_s_q;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic       int_q, int_d, err_q, err_d, busy_q, busy_d;
  logic       tick, mid;
`ifdef UART_RX_PARITY_EN
  logic       par_err_q, par_err_d;
`else
  logic       unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (state_q == IDLE),
    .div    (baud_div),
    .tick   (tick)
  );

  // frame FSM: start qualification at mid-bit, then one sample per 16 ticks
  always_comb begin
    state_d = state_q;
    samp_d  = tick ? samp_q + 4'd1 : samp_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    int_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = state_q != IDLE;
    mid     = tick && (samp_q == 4'(OVERSAMPLE - 1));
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: if (!rx_s_q) begin
        state_d = START;
        samp_d  = '0;
      end
      START: if (tick && samp_q == 4'(MID_SAMPLE)) begin
        state_d = rx_s_q ? IDLE : DATA;
        samp_d  = '0;
        bit_d   = '0;
      end
      DATA: if (mid) begin
        sh_d  = {rx_s_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        par_err_d = rx_s_q != (^sh_q ^ parity_odd);
        state_d   = STOP;
      end
`endif
      STOP: if (mid) begin
        // a low stop bit may be a break: park in WAIT_HIGH rather than decode zeros
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
        err_d  = !rx_s_q || par_err_q;
`else
        err_d  = !rx_s_q;
`endif
        int_d  = !err_d;
        data_d = int_d ? sh_q : data_q;
      end
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, synchroniser and registered status outputs
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      samp_q    <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      int_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      int_q     <= int_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end

  assign rif.recv_data  = data_q;
  assign rif.recv_int   = int_q;
  assign rif.recv_error = err_q;
  assign rif.recv_busy  = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at baud_div=3 (64 clk per bit) with hand-computed expectations
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        parity_odd = 1'b0;
  int          errs = 0, checks = 0;
  int          n_int = 0, n_err = 0;
  logic [7:0]  last_data = 8'h00;
  logic        busy_seen = 1'b0, busy_mid = 1'b0;
  int          i0, e0;

  uart_rx_if rif ();

  uart_rx #(.DIV_W(16)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .rx         (rx),
    .baud_div   (baud_div),
    .parity_odd (parity_odd),
    .rif        (rif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rif.recv_int) begin
      n_int++;
      last_data = rif.recv_data;
    end
    if (rif.recv_error) n_err++;
    if (rif.recv_busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_t(input logic v);
    @(negedge clk) rx = v;
    repeat (63) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_b);
    bit_t(1'b0);
    busy_mid = rif.recv_busy;
    for (int i = 0; i < 8; i++) bit_t(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_t(par_b);
`else
    if (par_b === 1'bx) $display("parity bit unknown");
`endif
    bit_t(stop_b);
  endtask

  task automatic idle(input int n);
    @(negedge clk) rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    i0 = n_int;
    e0 = n_err;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(rif.recv_data), 32'h00);
    chk("rst_int", 32'(rif.recv_int), 32'h0);
    chk("rst_busy", 32'(rif.recv_busy), 32'h0);
    chk("rst_err", 32'(rif.recv_error), 32'h0);
    arst_n = 1'b1;
    idle(10);

    mark();
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_busy_mid", 32'(busy_mid), 32'h1);
    @(negedge clk);
    chk("a5_busy_after", 32'(rif.recv_busy), 32'h0);
    idle(40);
    chk("a5_int_cnt", 32'(n_int - i0), 32'd1);
    chk("a5_data", 32'(last_data), 32'hA5);
    chk("a5_port_data", 32'(rif.recv_data), 32'hA5);
    chk("a5_err_cnt", 32'(n_err - e0), 32'd0);

    mark();
    send(8'h00, 1'b1, 1'b0);
    chk("b2b_first", 32'(last_data), 32'h00);
    send(8'hFF, 1'b1, 1'b1);
    idle(40);
    chk("b2b_int_cnt", 32'(n_int - i0), 32'd2);
    chk("b2b_data", 32'(last_data), 32'hFF);
    chk("b2b_err_cnt", 32'(n_err - e0), 32'd0);

    mark();
    busy_seen = 1'b0;
    @(negedge clk) rx = 1'b0;
    repeat (19) @(negedge clk);
    idle(100);
    chk("false_busy_seen", 32'(busy_seen), 32'h1);
    chk("false_busy_now", 32'(rif.recv_busy), 32'h0);
    chk("false_int_cnt", 32'(n_int - i0), 32'd0);
    chk("false_err_cnt", 32'(n_err - e0), 32'd0);

    mark();
    send(8'h3C, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    chk("brk_err_cnt", 32'(n_err - e0), 32'd1);
    chk("brk_int_cnt", 32'(n_int - i0), 32'd0);
    chk("brk_data_kept", 32'(rif.recv_data), 32'hFF);
    chk("brk_wait_high", 32'(rif.recv_busy), 32'h1);
    idle(100);
    chk("brk_idle", 32'(rif.recv_busy), 32'h0);
    mark();
    send(8'h12, 1'b1, 1'b0);
    idle(40);
    chk("post_brk_int", 32'(n_int - i0), 32'd1);
    chk("post_brk_data", 32'(last_data), 32'h12);

    mark();
    bit_t(1'b0);
    bit_t(1'b1);
    bit_t(1'b0);
    bit_t(1'b1);
    repeat (10) @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    chk("amid_data", 32'(rif.recv_data), 32'h00);
    chk("amid_busy", 32'(rif.recv_busy), 32'h0);
    chk("amid_int", 32'(rif.recv_int), 32'h0);
    chk("amid_err", 32'(rif.recv_error), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    arst_n = 1'b1;
    idle(200);
    chk("amid_no_pulse", 32'(n_int - i0 + n_err - e0), 32'd0);
    send(8'h81, 1'b1, 1'b0);
    idle(40);
    chk("post_rst_int", 32'(n_int - i0), 32'd1);
    chk("post_rst_data", 32'(rif.recv_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    mark();
    send(8'h07, 1'b1, 1'b1);
    idle(40);
    chk("par_good_int", 32'(n_int - i0), 32'd1);
    chk("par_good_data", 32'(rif.recv_data), 32'h07);
    mark();
    send(8'h07, 1'b1, 1'b0);
    idle(40);
    chk("par_bad_err", 32'(n_err - e0), 32'd1);
    chk("par_bad_int", 32'(n_int - i0), 32'd0);
    chk("par_bad_data", 32'(rif.recv_data), 32'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
